// File: rtl/hdmi_pixel_reader.sv
// HDMI timing generator and RGB565 line-FIFO consumer: pops one pixel per active slot and expands it to RGB888.
// Outputs lag the h/v counters by one cycle; output waits in FILL until the FIFO holds START_LEVEL words.
module hdmi_pixel_reader #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter bit SYNC_POL    = 1'b1,
  parameter int START_LEVEL = 1024,
  parameter int LVL_W       = 15
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             enable,
  output logic             rd_en,
  input  logic [15:0]      rd_data,
  input  logic             rd_empty,
  input  logic [LVL_W-1:0] rd_water_level,
  output logic             frame_start,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             underflow,
  input  logic             underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active0;
  logic          h_sync0;
  logic          v_sync0;
  logic          at_origin;
  logic          level_ok;
  logic          run0;
  logic          rd_vld;

  // run0 also covers the FILL->RUN origin cycle so the first pixel of the frame is not lost.
  always_comb begin
    active0   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    h_sync0   = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    v_sync0   = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    level_ok  = rd_water_level >= LVL_W'(START_LEVEL);
    run0      = (state == RUN) || ((state == FILL) && at_origin && level_ok);
    rd_en     = run0 && active0 && !rd_empty;
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n || !enable) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      de          <= 1'b0;
      rd_vld      <= 1'b0;
      underflow   <= 1'b0;
    end else if (state == IDLE) begin
      state       <= FILL;
      frame_start <= 1'b1;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      de          <= 1'b0;
      rd_vld      <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state <= run0 ? RUN : FILL;
      if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      frame_start <= (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
      hs          <= h_sync0 ? SYNC_POL : ~SYNC_POL;
      vs          <= v_sync0 ? SYNC_POL : ~SYNC_POL;
      de          <= run0 && active0;
      rd_vld      <= rd_en;
      // A starved active pixel still goes out (black); set beats clear.
      if (run0 && active0 && rd_empty)
        underflow <= 1'b1;
      else if (underflow_clr)
        underflow <= 1'b0;
    end
  end

  // FIFO data is valid the cycle after the pop, which is the cycle de is high.
  assign r = rd_vld ? {rd_data[15:11], rd_data[15:13]} : 8'd0;
  assign g = rd_vld ? {rd_data[10:5], rd_data[10:9]}   : 8'd0;
  assign b = rd_vld ? {rd_data[4:0], rd_data[4:2]}     : 8'd0;

endmodule

// File: tb/tb_hdmi_pixel_reader.sv
// Bench for hdmi_pixel_reader on a small 14x7 raster: a frame-position model plus a queue-backed FIFO.
module tb_hdmi_pixel_reader;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int START = 16;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        rd_en;
  logic [15:0] rd_data = 16'h0;
  logic        rd_empty = 1'b0;
  logic [14:0] rd_water_level = 15'd15;
  logic        frame_start, hs, vs, de, underflow;
  logic        underflow_clr = 1'b0;
  logic [7:0]  r, g, b;

  always #5 rd_clk = ~rd_clk;

  hdmi_pixel_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .START_LEVEL(START), .LVL_W(15)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_water_level(rd_water_level), .frame_start(frame_start),
    .hs(hs), .vs(vs), .de(de), .r(r), .g(g), .b(b),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] q[$];
  bit          force_empty = 0;
  // Model: mode 0 idle, 1 filling, 2 running; pos = linear raster position of stage 0.
  int          mstate = 0;
  int          pos = 0;
  bit          mvalid = 0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_uf = 1'b0;
  logic [23:0] e_rgb = 24'h0;
  logic        d_rd_en = 1'b0;
  logic [23:0] cap [3];
  int          ncap = 0;

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r5 = int'(p) >> 11;
    int g6 = (int'(p) >> 5) & 63;
    int b5 = int'(p) & 31;
    return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One pixel clock: check rd_en mid-cycle, advance model, feed FIFO data, check registered outputs.
  task automatic step();
    int          h, v;
    bit          act, run_c, exp_rd;
    logic [15:0] pix;
    if (q.size() < 40) repeat (100) q.push_back(16'($urandom));
    rd_empty = force_empty || (q.size() == 0);
    #1;
    h      = pos % HT;
    v      = pos / HT;
    act    = (h < HA) && (v < VA);
    run_c  = mvalid && (mstate == 2 || (mstate == 1 && pos == 0 && rd_water_level >= 15'(START)));
    exp_rd = run_c && act && !rd_empty;
    d_rd_en = rd_en;
    if (mvalid) chk("rd_en", rd_en, exp_rd);
    pix   = 16'h0;
    e_rgb = 24'h0;
    if (exp_rd) pix = q.pop_front();
    if (!rd_rst_n || !enable) begin
      if (!rd_rst_n) mvalid = 1;
      mstate = 0; pos = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_uf = 0;
    end else if (mstate == 0) begin
      mstate = 1;
      e_hs = 1; e_vs = 1; e_de = 0; e_fs = 1; e_uf = 0;
    end else begin
      e_hs = !(h >= HA + HF && h < HA + HF + HS);
      e_vs = !(v >= VA + VF && v < VA + VF + VS);
      e_de = run_c && act;
      e_fs = (h == 0) && (v == VA);
      if (run_c && act && rd_empty) e_uf = 1;
      else if (underflow_clr) e_uf = 0;
      if (exp_rd) e_rgb = expand(pix);
      mstate = run_c ? 2 : 1;
      pos = (pos + 1) % FRAME;
    end
    @(posedge rd_clk);
    #1;
    rd_data = exp_rd ? pix : 16'($urandom);
    @(negedge rd_clk);
    if (mvalid) begin
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("de", de, e_de);
      chk("frame_start", frame_start, e_fs);
      chk("underflow", underflow, e_uf);
      chk("rgb", {r, g, b}, e_rgb);
    end
    if (de === 1'b1 && ncap < 3) begin
      cap[ncap] = {r, g, b};
      ncap++;
    end
  endtask

  initial begin
    int k, nr, nf, de_seen;
    q.push_back(16'hF800);
    q.push_back(16'h07E0);
    q.push_back(16'h001F);
    repeat (200) q.push_back(16'($urandom));

    // Reset held with enable high.
    repeat (3) step();
    chk("rst_rd_en", d_rd_en, 0);
    chk("rst_de", de, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_rgb", {r, g, b}, 0);
    rd_rst_n = 1'b1;
    step();
    chk("fill_fs", frame_start, 1);
    step();
    chk("fs_once", frame_start, 0);

    // Below the start level: never leaves FILL.
    de_seen = 0;
    repeat (150) begin
      step();
      if (de === 1'b1) de_seen++;
    end
    chk("fill_no_de", de_seen, 0);
    rd_water_level = 15'd16;
    k = 0;
    while (de !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    chk("first_de_pos", pos, 1);

    // Primary colours from the preloaded words.
    repeat (30) step();
    chk("ncap", ncap, 3);
    chk("pix_red", cap[0], 24'hFF0000);
    chk("pix_green", cap[1], 24'h00FF00);
    chk("pix_blue", cap[2], 24'h0000FF);

    // One starved active pixel.
    k = 0;
    while (!(mstate == 2 && pos % HT == 3 && pos / HT < VA) && k < 200) begin
      step();
      k++;
    end
    force_empty = 1;
    rd_empty = 1'b1;
    #1;
    chk("uf_rd_en", rd_en, 0);
    step();
    force_empty = 0;
    chk("uf_de", de, 1);
    chk("uf_black", {r, g, b}, 0);
    chk("uf_flag", underflow, 1);
    repeat (3) step();
    chk("uf_sticky", underflow, 1);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("uf_clr", underflow, 0);

    // Disable mid-line, then re-enable.
    k = 0;
    while (!(mstate == 2 && pos % HT == 4 && pos / HT < VA) && k < 200) begin
      step();
      k++;
    end
    enable = 1'b0;
    step();
    chk("dis_de", de, 0);
    chk("dis_hs", hs, 1);
    chk("dis_vs", vs, 1);
    step();
    enable = 1'b1;
    step();
    chk("reen_fs", frame_start, 1);

    // Two whole frames in RUN.
    k = 0;
    while (!(mstate == 2 && pos == 0) && k < 300) begin
      step();
      k++;
    end
    for (int f = 0; f < 2; f++) begin
      nr = 0;
      nf = 0;
      repeat (FRAME) begin
        step();
        nr += int'(d_rd_en);
        nf += int'(frame_start);
      end
      chk("frame_rd_en_count", nr, 32);
      chk("frame_fs_count", nf, 1);
    end

    // Randomized traffic against the model.
    repeat (1500) begin
      force_empty   = ($urandom_range(0, 15) == 0);
      underflow_clr = ($urandom_range(0, 9) == 0);
      enable        = ($urandom_range(0, 199) != 0);
      rd_rst_n      = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 99) == 0) rd_water_level = 15'($urandom_range(10, 25));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
